// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and memory port bundle of the shared-memory arbiter
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            i_req;
  logic [AW-1:0]   i_addr;
  logic [DW-1:0]   i_rdata;
  logic            i_ack;
  logic            d_req;
  logic            d_we;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic [DW/8-1:0] d_wmask;
  logic [DW-1:0]   d_rdata;
  logic            d_ack;
  logic            m_en;
  logic            m_we;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic [DW/8-1:0] m_wmask;
  logic [DW-1:0]   m_rdata;
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wmask, m_rdata,
    output i_rdata, i_ack, d_rdata, d_ack, m_en, m_we, m_addr, m_wdata, m_wmask
  );
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wmask, m_rdata,
    input  i_rdata, i_ack, d_rdata, d_ack, m_en, m_we, m_addr, m_wdata, m_wmask
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one fixed-latency memory port between fetch and load/store
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  state_t          state;
  logic            last_d;
  logic            gnt_d;
  logic            we_q;
  logic            pick_d;
  logic            en_q;
  logic            mwe_q;
  logic            i_ack_q;
  logic            d_ack_q;
  logic [3:0]      cnt;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   i_rdata_q;
  logic [DW-1:0]   d_rdata_q;
  logic [DW/8-1:0] wmask_q;
  always_comb pick_d = bus.d_req & (~bus.i_req | ~last_d);
  assign bus.m_en    = en_q;
  assign bus.m_we    = mwe_q;
  assign bus.m_addr  = addr_q;
  assign bus.m_wdata = wdata_q;
  assign bus.m_wmask = wmask_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.i_ack   = i_ack_q;
  assign bus.d_ack   = d_ack_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      last_d    <= 1'b1;
      gnt_d     <= 1'b0;
      we_q      <= 1'b0;
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      en_q      <= 1'b0;
      mwe_q     <= 1'b0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      case (state)
        IDLE: if (bus.i_req | bus.d_req) begin
          state   <= ACCESS;
          gnt_d   <= pick_d;
          last_d  <= pick_d;
          we_q    <= pick_d & bus.d_we;
          addr_q  <= pick_d ? bus.d_addr : bus.i_addr;
          wdata_q <= pick_d ? bus.d_wdata : '0;
          wmask_q <= pick_d ? bus.d_wmask : '0;
          en_q    <= 1'b1;
          mwe_q   <= pick_d & bus.d_we;
          busy    <= 1'b1;
        end
        ACCESS: begin
          state <= WAIT;
          cnt   <= 4'(MEM_LAT);
          en_q  <= 1'b0;
          mwe_q <= 1'b0;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state   <= RESP;
            i_ack_q <= ~gnt_d;
            d_ack_q <= gnt_d;
            if (!gnt_d) i_rdata_q <= bus.m_rdata;
            else if (!we_q) d_rdata_q <= bus.m_rdata;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized transaction-level check of the shared-memory arbiter
module tb_mem_port_arbiter;
  localparam int L = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;
  always #5 clk = ~clk;
  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();
  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(L)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .busy(busy)
  );
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int free_at = 0;
  int g_cyc = -100;
  bit last_d = 1'b1;
  bit g_d, g_we, g_drop, i_pend, d_pend, wfix;
  logic [31:0] g_addr = '0;
  logic [31:0] g_wdata = '0;
  logic [3:0] g_mask = '0;
  logic [31:0] exp_i = '0;
  logic [31:0] exp_d = '0;
  int i_prob = 0, d_prob = 0, st_prob = 0, drop_prob = 0;
  logic [31:0] i_base = '0, i_amask = '0, d_base = '0, d_amask = '0;
  logic [31:0] ref_mem [256];
  logic [31:0] mem [256];
  bit mem_init = 1'b0;
  int pend_cnt = 0;
  logic [31:0] pend_data = '0;
  function automatic logic [31:0] seed_word(int i);
    return (i == 4) ? 32'h0050_0093 : ((32'(i) * 32'h9E37_79B9) ^ 32'h0F1E_2D3C);
  endfunction
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] = seed_word(i);
      mem_init = 1'b1;
    end
    if (bus.m_en === 1'b1) begin
      if (bus.m_we === 1'b1)
        for (int b = 0; b < 4; b++)
          if (bus.m_wmask[b]) mem[bus.m_addr[9:2]][8*b +: 8] = bus.m_wdata[8*b +: 8];
      pend_data = mem[bus.m_addr[9:2]];
      pend_cnt = L;
    end else if (pend_cnt > 0) pend_cnt--;
    bus.m_rdata <= (pend_cnt == 1) ? pend_data : $urandom;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask
  task automatic chk_zero();
    chk("rst_m_en", 32'(bus.m_en), '0);
    chk("rst_m_we", 32'(bus.m_we), '0);
    chk("rst_m_addr", bus.m_addr, '0);
    chk("rst_m_wdata", bus.m_wdata, '0);
    chk("rst_m_wmask", 32'(bus.m_wmask), '0);
    chk("rst_i_rdata", bus.i_rdata, '0);
    chk("rst_d_rdata", bus.d_rdata, '0);
    chk("rst_i_ack", 32'(bus.i_ack), '0);
    chk("rst_d_ack", 32'(bus.d_ack), '0);
    chk("rst_busy", 32'(busy), '0);
  endtask
  task automatic drive();
    if (!i_pend && int'($urandom_range(99)) < i_prob) begin
      i_pend = 1'b1;
      bus.i_req = 1'b1;
      bus.i_addr = i_base | ($urandom & i_amask);
    end
    if (!d_pend && int'($urandom_range(99)) < d_prob) begin
      d_pend = 1'b1;
      bus.d_req = 1'b1;
      bus.d_addr = d_base | ($urandom & d_amask);
      bus.d_we = int'($urandom_range(99)) < st_prob;
      bus.d_wdata = wfix ? 32'hDEAD_BEEF : $urandom;
      bus.d_wmask = wfix ? 4'hF : 4'($urandom);
    end
  endtask
  task automatic arb();
    if (cyc >= free_at && (bus.i_req || bus.d_req)) begin
      g_d = bus.d_req && (!bus.i_req || !last_d);
      last_d = g_d;
      g_cyc = cyc;
      free_at = cyc + 3 + L;
      g_addr = g_d ? bus.d_addr : bus.i_addr;
      g_we = g_d && bus.d_we;
      g_wdata = bus.d_wdata;
      g_mask = g_d ? bus.d_wmask : 4'h0;
      g_drop = g_d && (int'($urandom_range(99)) < drop_prob);
    end
  endtask
  task automatic step();
    logic [7:0] idx;
    bit men, ack;
    @(negedge clk);
    cyc++;
    men = (cyc == g_cyc + 1);
    ack = (cyc == g_cyc + 2 + L);
    idx = g_addr[9:2];
    if (ack) begin
      if (!g_d) exp_i = ref_mem[idx];
      else if (!g_we) exp_d = ref_mem[idx];
      else for (int b = 0; b < 4; b++) if (g_mask[b]) ref_mem[idx][8*b +: 8] = g_wdata[8*b +: 8];
    end
    chk("m_en", 32'(bus.m_en), 32'(men));
    chk("m_we", 32'(bus.m_we), 32'(men & g_we));
    chk("i_ack", 32'(bus.i_ack), 32'(ack & !g_d));
    chk("d_ack", 32'(bus.d_ack), 32'(ack & g_d));
    chk("ack_excl", 32'(bus.i_ack & bus.d_ack), '0);
    chk("busy", 32'(busy), 32'(cyc > g_cyc && cyc <= g_cyc + 2 + L));
    chk("i_rdata", bus.i_rdata, exp_i);
    chk("d_rdata", bus.d_rdata, exp_d);
    if (cyc > g_cyc && cyc <= g_cyc + 1 + L) begin
      chk("m_addr", bus.m_addr, g_addr);
      chk("m_wmask", 32'(bus.m_wmask), 32'(g_mask));
      if (g_d) chk("m_wdata", bus.m_wdata, g_wdata);
    end
    if (ack && g_d) begin
      d_pend = 1'b0;
      bus.d_req = 1'b0;
    end
    if (ack && !g_d) begin
      i_pend = 1'b0;
      bus.i_req = 1'b0;
    end
    if (g_d && g_drop && cyc == g_cyc + 1) bus.d_req = 1'b0;
    drive();
    arb();
  endtask
  task automatic hold_reset(input int n);
    rst = 1'b0;
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    i_pend = 1'b0;
    d_pend = 1'b0;
    #1;
    chk_zero();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cyc++;
      chk_zero();
    end
  endtask
  task automatic release_rst();
    @(negedge clk);
    cyc++;
    chk_zero();
    rst = 1'b1;
    last_d = 1'b1;
    g_cyc = -100;
    free_at = cyc;
    exp_i = '0;
    exp_d = '0;
    drive();
    arb();
  endtask
  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = seed_word(i);
    bus.i_req = 1'b1;
    bus.d_req = 1'b1;
    bus.i_addr = 32'h40;
    bus.d_addr = 32'h280;
    bus.d_we = 1'b0;
    bus.d_wdata = '0;
    bus.d_wmask = '0;
    i_pend = 1'b1;
    d_pend = 1'b1;
    wfix = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      cyc++;
      chk_zero();
    end
    i_amask = 32'h7C;
    d_base = 32'h200;
    d_amask = 32'h7C;
    i_prob = 100;
    d_prob = 100;
    st_prob = 50;
    release_rst();
    repeat (24) step();
    i_prob = 0;
    d_prob = 0;
    repeat (14) step();
    i_base = 32'h10;
    i_amask = '0;
    i_prob = 100;
    step();
    i_prob = 0;
    repeat (6) step();
    d_base = 32'h100;
    d_amask = '0;
    st_prob = 100;
    wfix = 1'b1;
    d_prob = 100;
    step();
    d_prob = 0;
    repeat (6) step();
    st_prob = 0;
    wfix = 1'b0;
    d_prob = 100;
    step();
    d_prob = 0;
    repeat (6) step();
    drop_prob = 100;
    d_base = 32'h104;
    d_prob = 100;
    step();
    d_prob = 0;
    repeat (8) step();
    drop_prob = 0;
    d_base = 32'h200;
    d_amask = 32'h7C;
    d_prob = 100;
    step();
    d_prob = 0;
    repeat (2) step();
    hold_reset(3);
    release_rst();
    d_prob = 100;
    step();
    d_prob = 0;
    repeat (6) step();
    i_base = '0;
    i_amask = 32'h7C;
    d_base = '0;
    d_amask = 32'h7C;
    i_prob = 30;
    d_prob = 30;
    st_prob = 40;
    drop_prob = 20;
    repeat (1500) step();
    i_prob = 0;
    d_prob = 0;
    drop_prob = 0;
    repeat (14) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
